// File: rtl/arb8_pkg.sv
// Shared definitions for the eight-requester scheduler.
//   N_REQ   : number of requesters
//   ID_W    : width of a requester index
//   state_t : scheduler FSM states
package arb8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/arb8_pick.sv
// Combinational winner picker for the scheduler.
//   req    [7:0] in  : request vector
//   ptr    [2:0] in  : round-robin pointer (last winner); ignored in fixed mode
//   any          out : at least one request present
//   id     [2:0] out : winning requester index (0 when none)
//   onehot [7:0] out : one-hot form of id (0 when none)
// Macro ARB8_SCHED_RR_EN selects round-robin; otherwise the highest set index wins.
module arb8_pick
  import arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  id,
  output logic [N_REQ-1:0] onehot
);

  assign any    = |req;
  assign onehot = any ? (N_REQ'(1) << id) : '0;

`ifdef ARB8_SCHED_RR_EN
  logic [3:0]         sh;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    k;

  // Rotate so that requester ptr+1 lands in bit 0, take the lowest set bit,
  // then undo the rotation to get the absolute index.
  always_comb begin
    sh  = {1'b0, ptr} + 4'd1;
    dbl = {req, req} >> sh;
    rot = dbl[N_REQ-1:0];
    k   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) k = ID_W'(i);
    end
    id = k + ptr + ID_W'(1);
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Ascending scan, last hit wins: bit 7 has the highest priority.
  always_comb begin
    id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) id = ID_W'(i);
    end
  end
`endif

endmodule

// File: rtl/arb8_sched.sv
// Eight-requester scheduler for one shared downstream resource.
// Grants one requester at a time, holds the grant until the owner signals done
// or drops its request, and revokes it after HOLD_MAX cycles (0 = no limit).
//   clk          in  : rising-edge clock
//   rst          in  : asynchronous active-high reset
//   req    [7:0] in  : request vector, level
//   done         in  : owner finished (sampled only while granted)
//   gnt    [7:0] out : registered one-hot grant
//   gnt_id [2:0] out : registered index of the granted requester
//   busy         out : high while a grant is active
//   timeout      out : one-cycle pulse when a grant is revoked by expiry alone
// Macro ARB8_SCHED_RR_EN: round-robin selection; undefined = fixed priority.
module arb8_sched
  import arb8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  localparam bit             TO_EN  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] EXP_AT = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             to_q, to_d;

  logic             rel_drop, rel_exp;
  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  ptr_w;

`ifdef ARB8_SCHED_RR_EN
  logic [ID_W-1:0] ptr_q;

  // Pointer remembers the last winner; search restarts just after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '1;
    end else if (state_q == IDLE && pick_any) begin
      ptr_q <= pick_id;
    end
  end
  assign ptr_w = ptr_q;
`else
  assign ptr_w = '1;
`endif

  arb8_pick u_pick (
    .req    (req),
    .ptr    (ptr_w),
    .any    (pick_any),
    .id     (pick_id),
    .onehot (pick_oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    to_d     = 1'b0;
    rel_drop = ~req[id_q];
    rel_exp  = TO_EN && (cnt_q == EXP_AT);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          id_d    = pick_id;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done || rel_drop || rel_exp) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          // A voluntary release in the same cycle as expiry is not a timeout.
          to_d    = rel_exp && !done && !rel_drop;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = (state_q == GRANT);
  assign timeout = to_q;

endmodule

// File: tb/tb_arb8_sched.sv
module tb_arb8_sched;

  localparam int HOLD = 16;
`ifdef ARB8_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  arb8_sched #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 = none), cycles held so far, last winner.
  int   m_owner;
  int   m_held;
  int   m_ptr;
  logic m_to;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r);
    int w = -1;
    if (RR) begin
      for (int k = 8; k >= 1; k--) if (r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
    end else begin
      for (int i = 0; i < 8; i++) if (r[i]) w = i;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 7;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        int w;
        w = pick(req);
        if (w >= 0) begin
          m_owner = w;
          m_held  = 1;
          m_ptr   = w;
        end
      end else if (done || !req[m_owner] || (HOLD != 0 && m_held == HOLD)) begin
        m_to    = (HOLD != 0 && m_held == HOLD) && !done && req[m_owner];
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    ei = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    chk({tag, ".gnt"},     gnt,     eg);
    chk({tag, ".gnt_id"},  gnt_id,  ei);
    chk({tag, ".busy"},    busy,    (m_owner >= 0));
    chk({tag, ".timeout"}, timeout, m_to);
  endtask

  task automatic step_chk(input string tag);
    step();
    check_model(tag);
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int len;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    model_reset();

    // Reset held with all requests asserted: outputs stay clear.
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_gnt",     gnt,     8'h00);
      chk("rst_gnt_id",  gnt_id,  3'd0);
      chk("rst_busy",    busy,    1'b0);
      chk("rst_timeout", timeout, 1'b0);
    end
    rst = 1'b0;
    model_reset();
    step_chk("rst_rel");
    chk("first_grant", gnt, RR ? 8'h01 : 8'h80);

    // All requesting, done one cycle after each grant: RR walks 0..7 and wraps.
    for (int i = 0; i < 9; i++) begin
      chk("sweep_id", gnt_id, RR ? 3'(i % 8) : 3'd7);
      done = 1'b1;
      step_chk("sweep_rel");
      chk("sweep_gap", gnt, 8'h00);
      done = 1'b0;
      step_chk("sweep_gnt");
    end

    // Table-driven sequence from reset.
    tbl[0]  = '{8'h44, 1'b0, RR ? 8'h04 : 8'h40, RR ? 3'd2 : 3'd6, 1'b1, 1'b0};
    tbl[1]  = '{8'h44, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h44, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    tbl[3]  = '{8'h44, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{8'h44, 1'b0, RR ? 8'h04 : 8'h40, RR ? 3'd2 : 3'd6, 1'b1, 1'b0};
    tbl[5]  = '{8'h44, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[6]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[7]  = '{8'h01, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[9]  = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      step();
      chk($sformatf("tbl%0d.gnt", i),     gnt,     tbl[i].gnt);
      chk($sformatf("tbl%0d.gnt_id", i),  gnt_id,  tbl[i].id);
      chk($sformatf("tbl%0d.busy", i),    busy,    tbl[i].busy);
      chk($sformatf("tbl%0d.timeout", i), timeout, tbl[i].to);
    end

    // Expiry: grant held exactly HOLD cycles, timeout pulse, re-grant after one idle.
    apply_reset();
    req = 8'h10;
    step_chk("hold_first");
    len = 0;
    for (int c = 0; c < 40 && gnt == 8'h10; c++) begin
      len++;
      step_chk("hold");
    end
    chk("hold_len",     len,     HOLD);
    chk("hold_to",      timeout, 1'b1);
    chk("hold_gnt_off", gnt,     8'h00);
    step_chk("hold_regrant");
    chk("regrant_gnt", gnt,     8'h10);
    chk("regrant_to",  timeout, 1'b0);

    // done in the same cycle as expiry: no timeout pulse.
    apply_reset();
    req = 8'h10;
    step_chk("dx_grant");
    repeat (15) step_chk("dx_hold");
    done = 1'b1;
    step_chk("dx_rel");
    chk("dx_to",  timeout, 1'b0);
    chk("dx_gnt", gnt,     8'h00);
    done = 1'b0;

    // Owner drops its request: release without timeout, then serve the other.
    apply_reset();
    req = 8'h81;
    step_chk("drop_grant");
    chk("drop_grant_id", gnt_id, RR ? 3'd0 : 3'd7);
    req = 8'h81 & ~gnt;
    step_chk("drop_rel");
    chk("drop_gnt", gnt,     8'h00);
    chk("drop_to",  timeout, 1'b0);
    step_chk("drop_next");
    chk("drop_next_gnt", gnt, RR ? 8'h80 : 8'h01);

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    apply_reset();
    req = 8'h20;
    step_chk("ar_grant");
    chk("ar_gnt_before", gnt, 8'h20);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_gnt",    gnt,    8'h00);
    chk("ar_busy",   busy,   1'b0);
    chk("ar_gnt_id", gnt_id, 3'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 8'h41;
    step_chk("ar_after");
    chk("ar_ptr", gnt, RR ? 8'h01 : 8'h40);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      done = ($urandom_range(0, 19) == 0);
      step_chk("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb8_sched.md
# arb8_sched

Eight-requester scheduler that shares a single downstream resource among agents whose request lines previously drove the 8-to-3 priority encoder directly. Sits between the requester bank and the resource: registers one-hot grant and binary grant index, holds the grant until the owner finishes, and forcibly revokes it after a bounded hold time. Selection is round-robin or fixed-priority, chosen at compile time.

## Interface
- HOLD_MAX, 16: max cycles a grant is held; 0 disables timeout; must be < 2**CNT_W.
- CNT_W, 8: hold-counter width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector, bit i = requester i; level, held until served.
- done  in  1  owner finished; sampled only in GRANT.
- gnt  out  8  one-hot grant, registered; 8'h00 when none.
- gnt_id  out  3  binary index of granted requester; 0 when none.
- busy  out  1  1 while in GRANT.
- timeout  out  1  one-cycle pulse when a grant is revoked by expiry.

## Operation
- States: IDLE, GRANT. Reset: IDLE, gnt=8'h00, gnt_id=0, busy=0, timeout=0, hold counter 0, RR pointer 7.
- IDLE: if req!=0, pick winner, latch gnt/gnt_id, clear counter, go GRANT; else stay.
- GRANT: counter increments each cycle. Release when done=1, or req[gnt_id]=0, or (HOLD_MAX!=0 and counter==HOLD_MAX-1). On release: gnt=0, busy=0, go IDLE.
- timeout pulses only when release is caused solely by expiry; done or request drop in the same cycle takes precedence (no pulse).
- done in IDLE ignored. Changes to non-owner req bits during GRANT ignored.
- Round-robin: search order pointer+1 … pointer (mod 8, wrap 7->0); pointer updated to winner on each grant.
- Fixed priority: highest set index wins (bit 7 highest).
- Reset mid-GRANT: all outputs clear immediately (asynchronous), state IDLE.

## Timing
- req seen in IDLE at edge N -> gnt/gnt_id/busy valid after edge N (latency 1).
- Release condition at edge M -> gnt=0 after edge M; state IDLE one full cycle; next grant after edge M+1 at earliest. Minimum one idle cycle between grants.
- Maximum grant length HOLD_MAX cycles; timeout high in the first cycle after revocation (same cycle gnt drops).
- No combinational path from req/done to any output.

## Configuration
- ARB8_SCHED_RR_EN defined: round-robin selection with rotating pointer.
- Undefined: fixed priority, pointer register removed, identical to the encoder's priority order.

## Structure
- Package arb8_pkg: N_REQ=8, ID_W=3, state enum (IDLE, GRANT).
- Sub-module arb8_pick: combinational picker; inputs req[7:0], ptr[2:0]; outputs any, id[2:0], onehot[7:0]; rotate-by-ptr then priority-encode (ptr ignored in fixed mode).
- Top holds FSM, hold counter, pointer, output registers.

## Test plan
- Reset: assert rst with req=8'hFF -> gnt=8'h00, gnt_id=0, busy=0, timeout=0 throughout; after release first RR grant gnt=8'h01.
- req=8'h44 held, done pulsed each grant -> RR: gnt 8'h04, 8'h40, 8'h04 (ids 2,6,2), one zero cycle between; fixed: always 8'h40.
- req=8'hFF, done one cycle after each grant -> RR ids 0,1,2,…,7,0 (wrap).
- HOLD_MAX=16, req=8'h10 held, no done -> gnt=8'h10 exactly 16 cycles, timeout pulse 1 cycle with gnt=0, re-grant 8'h10 after one idle cycle.
- req=8'h81 (RR) -> grant id0; drop req[0] -> gnt=0 next cycle, no timeout, then grant 8'h80 id7; done and expiry same cycle -> no timeout pulse.
- rst asserted mid-grant (gnt=8'h20) -> gnt=8'h00, busy=0 immediately without clock edge; pointer back to 7.
